// File: rtl/vision_pkg.sv
// Shared types and constants for the vision front-end blocks.
// Used by the bounding-box tracker and its min/max accumulators.
package vision_pkg;

    typedef enum logic [1:0] {
        WAIT_SYNC,
        SCAN,
        PUBLISH
    } state_t;

    localparam logic [10:0] X_EMPTY = 11'h7FF;
    localparam logic [9:0]  Y_EMPTY = 10'h3FF;
    localparam int          COUNT_W = 20;

endpackage

// File: rtl/minmax_acc.sv
// Running minimum/maximum of one coordinate axis.
// Clear returns to the empty state (min = EMPTY, max = 0).
module minmax_acc #(
    parameter int             W     = 11,
    parameter logic [W-1:0]   EMPTY = '1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] value,
    output logic [W-1:0] min_val,
    output logic [W-1:0] max_val
);

    // Track extremes of every enabled sample since the last clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            min_val <= EMPTY;
            max_val <= '0;
        end else if (clr) begin
            min_val <= EMPTY;
            max_val <= '0;
        end else if (en) begin
            if (value < min_val) min_val <= value;
            if (value > max_val) max_val <= value;
        end
    end

endmodule

// File: rtl/blob_bbox_tracker.sv
// Finds the bounding box of target-coloured pixels in each frame.
// Publishes x/y/size and the renderer's change_x at every frame end.
module blob_bbox_tracker
    import vision_pkg::*;
#(
    parameter int          H_ACTIVE   = 1024,
    parameter int          V_ACTIVE   = 768,
    parameter logic [11:0] COLOR      = 12'hFFF,
    parameter int          NOM_WIDTH  = 64,
    parameter int          MIN_PIXELS = 16
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic [11:0] pixel_in,
    output logic [10:0] x_out,
    output logic [9:0]  y_out,
    output logic [10:0] width_out,
    output logic [9:0]  height_out,
    output logic [10:0] change_x_out,
    output logic        found_out,
    output logic        frame_done_out
);

    localparam logic [10:0] H_LIM = H_ACTIVE[10:0];
    localparam logic [9:0]  V_LIM = V_ACTIVE[9:0];
    localparam logic [10:0] NOM   = NOM_WIDTH[10:0];
    localparam logic [COUNT_W-1:0] MIN_CNT = MIN_PIXELS[COUNT_W-1:0];

    state_t               state;
    logic [COUNT_W-1:0]   count;
    logic                 fe_q;
    logic                 fe_cond;
    logic                 fe;
    logic                 match;
    logic                 clr;
    logic                 en;
    logic [10:0]          min_x;
    logic [10:0]          max_x;
    logic [9:0]           min_y;
    logic [9:0]           max_y;
    logic [10:0]          box_w;
    logic [9:0]           box_h;
    logic [10:0]          box_cx;

    assign match = (pixel_in == COLOR)
                 && (hcount_in < H_LIM)
                 && (vcount_in < V_LIM);

    // Edge-qualify so a stalled counter yields a single event.
    assign fe_cond = (vcount_in == V_LIM) && (hcount_in == 11'd0);
    assign fe      = fe_cond && !fe_q;

    assign clr = ((state == WAIT_SYNC) && fe) || (state == PUBLISH);
    assign en  = (state == SCAN) && match;

    assign box_w  = max_x - min_x + 11'd1;
    assign box_h  = max_y - min_y + 10'd1;
    assign box_cx = (box_w >= NOM) ? box_w - NOM : 11'd0;

    minmax_acc #(.W(11), .EMPTY(X_EMPTY)) u_acc_x (
        .clk     (clk_in),
        .rst     (rst_in),
        .clr     (clr),
        .en      (en),
        .value   (hcount_in),
        .min_val (min_x),
        .max_val (max_x)
    );

    minmax_acc #(.W(10), .EMPTY(Y_EMPTY)) u_acc_y (
        .clk     (clk_in),
        .rst     (rst_in),
        .clr     (clr),
        .en      (en),
        .value   (vcount_in),
        .min_val (min_y),
        .max_val (max_y)
    );

    // Frame FSM: sync to first frame end, scan, then publish once.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state          <= WAIT_SYNC;
            count          <= '0;
            fe_q           <= 1'b0;
            x_out          <= '0;
            y_out          <= '0;
            width_out      <= '0;
            height_out     <= '0;
            change_x_out   <= '0;
            found_out      <= 1'b0;
            frame_done_out <= 1'b0;
        end else begin
            fe_q           <= fe_cond;
            frame_done_out <= 1'b0;
            unique case (state)
                WAIT_SYNC: begin
                    if (fe) begin
                        count <= '0;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    if (en && (count != '1)) count <= count + 1'b1;
                    if (fe) state <= PUBLISH;
                end
                PUBLISH: begin
                    frame_done_out <= 1'b1;
                    count          <= '0;
                    state          <= SCAN;
                    if (count >= MIN_CNT) begin
                        x_out        <= min_x;
                        y_out        <= min_y;
                        width_out    <= box_w;
                        height_out   <= box_h;
                        change_x_out <= box_cx;
                        found_out    <= 1'b1;
                    end else begin
                        found_out    <= 1'b0;
                    end
                end
                default: state <= WAIT_SYNC;
            endcase
        end
    end

endmodule

// File: tb/tb_blob_bbox_tracker.sv
// Directed bench for blob_bbox_tracker: counters are driven sparsely
// so each "frame" only visits the pixels of interest plus frame end.
module tb_blob_bbox_tracker;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] h;
    logic [9:0]  v;
    logic [11:0] p;

    logic [10:0] x0, w0, cx0, x1, w1, cx1;
    logic [9:0]  y0, ht0, y1, ht1;
    logic        f0, d0, f1, d1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    blob_bbox_tracker dut (
        .clk_in         (clk),
        .rst_in         (rst),
        .hcount_in      (h),
        .vcount_in      (v),
        .pixel_in       (p),
        .x_out          (x0),
        .y_out          (y0),
        .width_out      (w0),
        .height_out     (ht0),
        .change_x_out   (cx0),
        .found_out      (f0),
        .frame_done_out (d0)
    );

    blob_bbox_tracker #(.MIN_PIXELS(1)) dut1 (
        .clk_in         (clk),
        .rst_in         (rst),
        .hcount_in      (h),
        .vcount_in      (v),
        .pixel_in       (p),
        .x_out          (x1),
        .y_out          (y1),
        .width_out      (w1),
        .height_out     (ht1),
        .change_x_out   (cx1),
        .found_out      (f1),
        .frame_done_out (d1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [10:0] hh, input logic [9:0] vv,
                         input logic [11:0] pp);
        h = hh;
        v = vv;
        p = pp;
        @(posedge clk);
        #1;
    endtask

    task automatic rect(input int x, input int y, input int w, input int ht);
        for (int yy = 0; yy < ht; yy++)
            for (int xx = 0; xx < w; xx++)
                drive(11'(x + xx), 10'(y + yy), 12'hFFF);
    endtask

    task automatic frame_end(input string tag, input int hold,
                             input int exp_pulses);
        int n = 0;
        int n1 = 0;
        for (int i = 0; i < hold; i++) begin
            drive(11'd0, 10'd768, 12'hFFF);
            if (d0) n++;
            if (d1) n1++;
        end
        for (int i = 0; i < 3; i++) begin
            drive(11'd1, 10'd768, 12'h000);
            if (d0) n++;
            if (d1) n1++;
        end
        check_eq({tag, "_pulses"}, n, exp_pulses);
        check_eq({tag, "_pulses1"}, n1, exp_pulses);
    endtask

    task automatic expect0(input string tag, input int x, input int y,
                           input int w, input int ht, input int cx,
                           input int f);
        check_eq({tag, "_x"}, x0, x);
        check_eq({tag, "_y"}, y0, y);
        check_eq({tag, "_w"}, w0, w);
        check_eq({tag, "_h"}, ht0, ht);
        check_eq({tag, "_cx"}, cx0, cx);
        check_eq({tag, "_found"}, f0, f);
    endtask

    task automatic expect1(input string tag, input int x, input int y,
                           input int w, input int ht, input int cx,
                           input int f);
        check_eq({tag, "_x1"}, x1, x);
        check_eq({tag, "_y1"}, y1, y);
        check_eq({tag, "_w1"}, w1, w);
        check_eq({tag, "_h1"}, ht1, ht);
        check_eq({tag, "_cx1"}, cx1, cx);
        check_eq({tag, "_found1"}, f1, f);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        h = '0;
        v = '0;
        p = '0;
        repeat (3) drive(11'd0, 10'd0, 12'h000);
        expect0("reset", 0, 0, 0, 0, 0, 0);
        check_eq("reset_done", d0, 0);

        // release mid-frame at row 100
        drive(11'd0, 10'd100, 12'h000);
        rst = 1'b0;
        rect(200, 300, 8, 8);
        frame_end("partial", 1, 0);
        expect0("partial", 0, 0, 0, 0, 0, 0);

        rect(200, 300, 8, 8);
        frame_end("sq", 1, 1);
        expect0("sq", 200, 300, 8, 8, 0, 1);
        expect1("sq", 200, 300, 8, 8, 0, 1);

        // wide rectangle with near-miss colours around it
        drive(11'd0, 10'd0, 12'hFFE);
        rect(10, 20, 100, 40);
        drive(11'd1023, 10'd767, 12'h0FF);
        frame_end("rect", 3, 1);
        expect0("rect", 10, 20, 100, 40, 36, 1);

        for (int i = 0; i < 5; i++) drive(11'(500 + i), 10'd600, 12'hFFF);
        frame_end("few", 1, 1);
        expect0("few", 10, 20, 100, 40, 36, 0);
        expect1("few", 500, 600, 5, 1, 0, 1);

        drive(11'd1023, 10'd767, 12'hFFF);
        frame_end("corner", 1, 1);
        expect0("corner", 10, 20, 100, 40, 36, 0);
        expect1("corner", 1023, 767, 1, 1, 0, 1);

        drive(11'd1100, 10'd300, 12'hFFF);
        drive(11'd1024, 10'd5, 12'hFFF);
        drive(11'd50, 10'd800, 12'hFFF);
        drive(11'd1500, 10'd900, 12'hFFF);
        frame_end("blank", 1, 1);
        expect1("blank", 1023, 767, 1, 1, 0, 0);
        check_eq("blank_found", f0, 0);

        // asynchronous reset in the middle of a scan
        rect(40, 50, 4, 4);
        #2;
        rst = 1'b1;
        #1;
        expect0("arst", 0, 0, 0, 0, 0, 0);
        expect1("arst", 0, 0, 0, 0, 0, 0);
        drive(11'd5, 10'd400, 12'h000);
        rst = 1'b0;
        rect(60, 500, 4, 4);
        frame_end("arst_part", 1, 0);
        expect0("arst_part", 0, 0, 0, 0, 0, 0);

        rect(40, 50, 70, 2);
        frame_end("post", 1, 1);
        expect0("post", 40, 50, 70, 2, 6, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
